// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer: FSM states, note codes,
// song table entry layout and the end-of-song duration marker.
package song_sequencer_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned DUR_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_OVER = 3'd3,
        S_WAIT_CLR  = 3'd4,
        S_GAP       = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    localparam logic [NOTE_W-1:0] N_REST = 4'd0;
    localparam logic [NOTE_W-1:0] N_C    = 4'd1;
    localparam logic [NOTE_W-1:0] N_D    = 4'd2;
    localparam logic [NOTE_W-1:0] N_E    = 4'd3;
    localparam logic [NOTE_W-1:0] N_F    = 4'd4;
    localparam logic [NOTE_W-1:0] N_G    = 4'd5;
    localparam logic [NOTE_W-1:0] N_A    = 4'd6;
    localparam logic [NOTE_W-1:0] N_B    = 4'd7;
    localparam logic [NOTE_W-1:0] N_C_HI = 4'd8;

    localparam logic [DUR_W-1:0] END_MARK = 4'd0;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } song_entry_t;

    function automatic song_entry_t mk_entry(input logic [NOTE_W-1:0] n,
                                             input logic [DUR_W-1:0]  d);
        song_entry_t e;
        e.note     = n;
        e.duration = d;
        return e;
    endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Song table: registered case lookup with one cycle of read latency.
// SONG_SEL picks the table; 0 is the shipped tune, 1..3 are short fixed songs.
module song_sequencer_rom
    import song_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned SONG_SEL = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_index,
    output song_entry_t      o_entry
);

    song_entry_t r_entry;
    song_entry_t w_entry;

    always_comb begin
        w_entry = mk_entry(N_REST, END_MARK);
        case (SONG_SEL)
            0: begin
                case (32'(i_index))
                    0: w_entry = mk_entry(N_C,    4'd1);
                    1: w_entry = mk_entry(N_E,    4'd1);
                    2: w_entry = mk_entry(N_G,    4'd1);
                    3: w_entry = mk_entry(N_C_HI, 4'd2);
                    4: w_entry = mk_entry(N_REST, 4'd1);
                    5: w_entry = mk_entry(N_G,    4'd1);
                    6: w_entry = mk_entry(N_E,    4'd1);
                    7: w_entry = mk_entry(N_C,    4'd3);
                    default: w_entry = mk_entry(N_REST, END_MARK);
                endcase
            end
            1: begin
                case (32'(i_index))
                    0: w_entry = mk_entry(N_C, 4'd2);
                    1: w_entry = mk_entry(N_D, 4'd1);
                    2: w_entry = mk_entry(N_E, END_MARK);
                    default: w_entry = mk_entry(N_REST, END_MARK);
                endcase
            end
            // Every slot filled, no end marker: note = index+1, duration 1 or 2.
            2: w_entry = mk_entry(NOTE_W'(i_index) + NOTE_W'(1),
                                  DUR_W'(i_index[0]) + DUR_W'(1));
            default: w_entry = mk_entry(N_REST, END_MARK);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_entry <= '0;
        else         r_entry <= w_entry;
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/song_sequencer.sv
// Initiator side of the note-player handshake: walks the song table, pulses Start,
// waits for Over, inserts a gap, advances. SONG_LOOP_EN: repeat the song until Stop.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter  int unsigned SONG_LEN   = 16,
    parameter  int unsigned GAP_CYCLES = 4,
    parameter  int unsigned SONG_SEL   = 0,
    localparam int unsigned IDX_W      = $clog2(SONG_LEN)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_play,
    input  logic              i_stop,
    input  logic              i_over,
    output logic [NOTE_W-1:0] o_note,
    output logic [DUR_W-1:0]  o_duration,
    output logic              o_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [IDX_W-1:0]  o_index
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic             NO_GAP   = (GAP_CYCLES == 0);

    state_t            r_state;
    logic [IDX_W-1:0]  r_index;
    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_duration;
    logic              r_start;
    logic              r_busy;
    logic              r_done;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_abort;

    state_t            w_state_nxt;
    logic [IDX_W-1:0]  w_index_nxt;
    logic [NOTE_W-1:0] w_note_nxt;
    logic [DUR_W-1:0]  w_duration_nxt;
    logic              w_start_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic              w_abort_nxt;
    song_entry_t       w_entry;
    logic              w_is_end;
    logic              w_last;
    logic              w_gap_end;
    logic              w_abort;

    // ROM is addressed with the next index so its data is ready during LOAD.
    song_sequencer_rom #(
        .IDX_W    (IDX_W),
        .SONG_SEL (SONG_SEL)
    ) u_rom (
        .i_clk    (i_clock),
        .i_reset  (i_reset),
        .i_index  (w_index_nxt),
        .o_entry  (w_entry)
    );

    assign w_is_end  = (w_entry.duration == END_MARK);
    assign w_last    = (r_index == LAST_IDX);
    assign w_gap_end = NO_GAP | (r_gap_cnt == GAP_LAST);
    assign w_abort   = r_abort | i_stop;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (i_play) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_is_end) begin
`ifdef SONG_LOOP_EN
                    // A marker at entry 0 would otherwise loop forever on nothing.
                    w_state_nxt = (w_abort || (r_index == '0)) ? S_FINISH : S_LOAD;
`else
                    w_state_nxt = S_FINISH;
`endif
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:     w_state_nxt = S_WAIT_OVER;
            S_WAIT_OVER: if (i_over)  w_state_nxt = S_WAIT_CLR;
            S_WAIT_CLR:  if (!i_over) w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_gap_end) begin
                    if (w_abort) begin
                        w_state_nxt = S_FINISH;
                    end else if (w_last) begin
`ifdef SONG_LOOP_EN
                        w_state_nxt = S_LOAD;
`else
                        w_state_nxt = S_FINISH;
`endif
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        w_index_nxt    = r_index;
        w_note_nxt     = r_note;
        w_duration_nxt = r_duration;
        w_gap_nxt      = r_gap_cnt;
        w_abort_nxt    = r_abort | (i_stop & (r_state != S_IDLE));
        w_start_nxt    = (w_state_nxt == S_ISSUE);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_done_nxt     = (w_state_nxt == S_FINISH);
        case (r_state)
            S_IDLE: begin
                if (i_play) begin
                    w_index_nxt = '0;
                    w_abort_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                if (!w_is_end) begin
                    w_note_nxt     = w_entry.note;
                    w_duration_nxt = w_entry.duration;
                end else if (w_state_nxt == S_LOAD) begin
                    w_index_nxt = '0;
                end
            end
            S_WAIT_CLR: w_gap_nxt = '0;
            S_GAP: begin
                if (!w_gap_end) begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end else if (w_state_nxt == S_LOAD) begin
                    w_index_nxt = w_last ? '0 : r_index + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_index    <= '0;
            r_note     <= '0;
            r_duration <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_gap_cnt  <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_index    <= w_index_nxt;
            r_note     <= w_note_nxt;
            r_duration <= w_duration_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    assign o_note     = r_note;
    assign o_duration = r_duration;
    assign o_start    = r_start;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_index    = r_index;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: three instances (3-entry song, full 16-entry
// song, end marker at entry 0), each driven by a behavioural note player.
module tb_song_sequencer;

    localparam int K = 3;

    typedef struct {
        int dut;
        bit is_done;
        int index;
        int note;
        int dur;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [2:0] play;
    logic [2:0] stop;
    logic [2:0] over;
    logic [2:0] start;
    logic [2:0] busy;
    logic [2:0] done;
    logic [3:0] note [3];
    logic [3:0] dur  [3];
    logic [3:0] idx  [3];

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    int  n_start [3];
    int  hold_note [3];
    int  hold_dur  [3];
    bit  wrap_seen = 0;
    int  prev_idx1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic ov;
        logic act;
        int   cnt;

        song_sequencer #(
            .SONG_LEN   (16),
            .GAP_CYCLES (4),
            .SONG_SEL   (g + 1)
        ) u_dut (
            .i_clock    (clk),
            .i_reset    (reset),
            .i_play     (play[g]),
            .i_stop     (stop[g]),
            .i_over     (over[g]),
            .o_note     (note[g]),
            .o_duration (dur[g]),
            .o_start    (start[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g]),
            .o_index    (idx[g])
        );

        // Player: Over rises Duration*K cycles after Start and clears one cycle later.
        always @(posedge clk) begin
            if (reset) begin
                ov  <= 1'b0;
                act <= 1'b0;
                cnt <= 0;
            end else begin
                if (ov) ov <= 1'b0;
                if (start[g]) begin
                    cnt <= K * int'(dur[g]);
                    act <= 1'b1;
                end else if (act) begin
                    if (cnt == 1) begin
                        ov  <= 1'b1;
                        act <= 1'b0;
                    end
                    cnt <= cnt - 1;
                end
            end
        end

        assign over[g] = ov;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic exp_start(input int d, input int i, input int n, input int du);
        ev_t e;
        e.dut = d; e.is_done = 1'b0; e.index = i; e.note = n; e.dur = du;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int d, input int i);
        ev_t e;
        e.dut = d; e.is_done = 1'b1; e.index = i; e.note = 0; e.dur = 0;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input int d, input bit is_done);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL dut%0d unexpected %s: idx=%0d note=%0d dur=%0d, required no event",
                     d, is_done ? "done" : "start", idx[d], note[d], dur[d]);
            return;
        end
        e = exp_q.pop_front();
        if (!is_done) begin
            hold_note[d] = e.note;
            hold_dur[d]  = e.dur;
        end
        if (e.dut != d || e.is_done != is_done || e.index != int'(idx[d]) ||
            (!is_done && (e.note != int'(note[d]) || e.dur != int'(dur[d])))) begin
            n_miss++;
            $display("FAIL event: got dut%0d %s idx=%0d note=%0d dur=%0d, required dut%0d %s idx=%0d note=%0d dur=%0d",
                     d, is_done ? "done" : "start", idx[d], note[d], dur[d],
                     e.dut, e.is_done ? "done" : "start", e.index, e.note, e.dur);
        end
    endtask

    // Monitor: pops the scoreboard on every Start/Done, checks held Note/Duration at Over.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (start[d]) begin
                    n_start[d] = n_start[d] + 1;
                    mon_check(d, 1'b0);
                end
                if (done[d]) mon_check(d, 1'b1);
                if (over[d]) begin
                    check($sformatf("dut%0d note held at over", d), int'(note[d]), hold_note[d]);
                    check($sformatf("dut%0d dur held at over", d), int'(dur[d]), hold_dur[d]);
                end
            end
            if (prev_idx1 == 15 && idx[1] == 4'd0) wrap_seen = 1'b1;
            prev_idx1 = int'(idx[1]);
        end else begin
            prev_idx1 = 0;
        end
    end

    // Plays one song on dut d; optional Stop after stop_at Starts, optional Play hammering.
    task automatic run_song(input int d, input int stop_at, input bit hammer, input int budget,
                            output int first_start, output int done_cyc);
        int c    = 0;
        int base = n_start[d];
        bit stopped = 1'b0;
        bit saw     = 1'b0;
        first_start = 0;
        done_cyc    = 0;
        @(posedge clk); #1;
        play[d] = 1'b1;
        while (!saw && c < budget) begin
            @(negedge clk);
            c++;
            if (start[d] && first_start == 0) first_start = c;
            if (done[d]) begin
                saw      = 1'b1;
                done_cyc = c;
            end
            @(posedge clk); #1;
            play[d] = 1'b0;
            stop[d] = 1'b0;
            if (!saw) begin
                if (stop_at > 0 && !stopped && (n_start[d] - base) >= stop_at) begin
                    stop[d] = 1'b1;
                    stopped = 1'b1;
                end
                if (hammer && busy[d] && (c % 3 == 0)) play[d] = 1'b1;
            end
        end
        check($sformatf("dut%0d done seen", d), int'(saw), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fs, dc, base;
        for (int d = 0; d < 3; d++) begin
            n_start[d] = 0; hold_note[d] = 0; hold_dur[d] = 0;
        end
        reset = 1'b1;
        play  = '0;
        stop  = '0;
        idle(3);
        check("reset busy",  int'(busy[0]),  0);
        check("reset start", int'(start[0]), 0);
        check("reset done",  int'(done[0]),  0);
        check("reset index", int'(idx[0]),   0);
        check("reset note",  int'(note[0]),  0);
        check("reset dur",   int'(dur[0]),   0);
        reset = 1'b0;
        idle(2);

        // 3-entry song {(1,2),(2,1),(3,0)}
        exp_start(0, 0, 1, 2);
        exp_start(0, 1, 2, 1);
`ifdef SONG_LOOP_EN
        exp_start(0, 0, 1, 2);
        exp_done(0, 0);
        run_song(0, 3, 1'b0, 300, fs, dc);
`else
        exp_done(0, 2);
        run_song(0, 0, 1'b0, 300, fs, dc);
`endif
        check("play to first start cycles", fs, 3);
        check("t1 queue drained", exp_q.size(), 0);
        idle(2);
        check("t1 busy after done", int'(busy[0]), 0);

        // Stop during entry 0
        exp_start(0, 0, 1, 2);
        exp_done(0, 0);
        run_song(0, 1, 1'b0, 300, fs, dc);
        check("t2 queue drained", exp_q.size(), 0);
        idle(2);
        check("t2 busy after done", int'(busy[0]), 0);

        // Play hammered while busy
        exp_start(0, 0, 1, 2);
        exp_start(0, 1, 2, 1);
`ifdef SONG_LOOP_EN
        exp_start(0, 0, 1, 2);
        exp_done(0, 0);
        run_song(0, 3, 1'b1, 300, fs, dc);
`else
        exp_done(0, 2);
        run_song(0, 0, 1'b1, 300, fs, dc);
`endif
        check("t3 queue drained", exp_q.size(), 0);
        idle(3);

        // Reset while waiting for Over
        exp_start(0, 0, 1, 2);
        base = n_start[0];
        play[0] = 1'b1;
        idle(1);
        play[0] = 1'b0;
        for (int i = 0; i < 10 && n_start[0] == base; i++) idle(1);
        check("t4 start seen", n_start[0] - base, 1);
        reset = 1'b1;
        idle(1);
        check("t4 busy after reset",  int'(busy[0]),  0);
        check("t4 start after reset", int'(start[0]), 0);
        check("t4 index after reset", int'(idx[0]),   0);
        check("t4 note after reset",  int'(note[0]),  0);
        reset = 1'b0;
        check("t4 queue drained", exp_q.size(), 0);
        idle(3);

        // Full 16-entry table without end marker
        for (int i = 0; i < 16; i++) exp_start(1, i, (i + 1) % 16, (i % 2) + 1);
`ifdef SONG_LOOP_EN
        exp_start(1, 0, 1, 1);
        exp_done(1, 0);
        run_song(1, 17, 1'b0, 2000, fs, dc);
        check("t5 wrap to index 0", int'(wrap_seen), 1);
`else
        exp_done(1, 15);
        run_song(1, 0, 1'b0, 2000, fs, dc);
        check("t5 no wrap after 15", int'(wrap_seen), 0);
`endif
        check("t5 queue drained", exp_q.size(), 0);
        idle(3);

        // End marker at entry 0: Done without any Start
        exp_done(2, 0);
        run_song(2, 0, 1'b0, 20, fs, dc);
        check("t6 done cycle", dc, 3);
        check("t6 queue drained", exp_q.size(), 0);
        idle(2);
        check("t6 busy after done", int'(busy[2]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
